// File: rtl/pdp11_operand_fetch.sv
// PDP-11 operand-fetch stage: resolves one (mode, reg, byte) specifier over a byte-wide sync memory.
// Define OPFETCH_ODD_ADDR_TRAP_EN to abort word accesses at odd addresses with odd_addr_err.
module pdp11_operand_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [2:0]        in_reg,
  input  logic              in_byte,
  input  logic [ADDR_W-1:0] in_pc,
  output logic [2:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              reg_wr_en,
  output logic [2:0]        reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_operand,
  output logic [DATA_W-1:0] out_ea,
  output logic              out_is_mem,
  output logic [ADDR_W-1:0] out_pc,
  output logic              odd_addr_err
);

  typedef enum logic [3:0] {IDLE, CALC, IDX_HI, IDX_LO, PTR_HI, PTR_LO, OP_HI, OP_LO, DONE} state_t;

  state_t            state_r, tgt_s, lo_s;
  logic              phase_r, byte_r, mem_rd_en_r, out_is_mem_r, err_r;
  logic [2:0]        mode_r, rsel_r;
  logic [7:0]        hi_r;
  logic [ADDR_W-1:0] pc_r, cur_addr_r, mem_addr_r, out_pc_r, pc_next_s, pc2_s, tgt_addr_s;
  logic [DATA_W-1:0] base_r, out_operand_r, out_ea_r, step_s, word_s, wr_data_s, base_s;
  logic              r7_s, wr_en_s, ill_s, launch_s, trap_s;

  assign in_ready     = (state_r == IDLE);
  assign out_valid    = (state_r == DONE);
  assign reg_rd_addr  = rsel_r;
  assign reg_wr_en    = (state_r == CALC) && wr_en_s;
  assign reg_wr_addr  = reg_wr_en ? rsel_r : 3'd0;
  assign reg_wr_data  = reg_wr_en ? wr_data_s : '0;
  assign mem_rd_en    = mem_rd_en_r;
  assign mem_addr     = mem_addr_r;
  assign out_operand  = out_operand_r;
  assign out_ea       = out_ea_r;
  assign out_is_mem   = out_is_mem_r;
  assign out_pc       = out_pc_r;
  assign odd_addr_err = err_r;

  assign r7_s     = (rsel_r == 3'd7);
  assign pc2_s    = pc_r + ADDR_W'(2);
  assign word_s   = {hi_r, mem_rd_data};
  assign step_s   = (byte_r && (rsel_r < 3'd6)) ? DATA_W'(1) : DATA_W'(2);
  assign launch_s = (state_r == CALC) || (((state_r == IDX_LO) || (state_r == PTR_LO)) && phase_r);

`ifdef OPFETCH_ODD_ADDR_TRAP_EN
  assign trap_s = ((tgt_s != OP_HI) || !byte_r) && (tgt_s != DONE) && tgt_addr_s[0];
`else
  assign trap_s = 1'b0;
`endif

  // Address generation: picks the next read sequence and any register writeback
  always_comb begin
    tgt_s      = DONE;
    tgt_addr_s = '0;
    wr_en_s    = 1'b0;
    wr_data_s  = reg_rd_data;
    base_s     = reg_rd_data;
    ill_s      = 1'b0;
    pc_next_s  = pc_r;
    lo_s       = OP_LO;
    case (state_r)
      CALC: begin
        case (mode_r)
          3'd0: ill_s = r7_s;
          3'd1: begin
            if (r7_s) begin
              ill_s = 1'b1;
            end else begin
              tgt_s      = OP_HI;
              tgt_addr_s = reg_rd_data;
            end
          end
          3'd2: begin
            tgt_s = OP_HI;
            if (r7_s) begin
              tgt_addr_s = pc_r;
              pc_next_s  = pc2_s;
            end else begin
              tgt_addr_s = reg_rd_data;
              wr_en_s    = 1'b1;
              wr_data_s  = reg_rd_data + step_s;
            end
          end
          3'd3: begin
            tgt_s = PTR_HI;
            if (r7_s) begin
              tgt_addr_s = pc_r;
              pc_next_s  = pc2_s;
            end else begin
              tgt_addr_s = reg_rd_data;
              wr_en_s    = 1'b1;
              wr_data_s  = reg_rd_data + DATA_W'(2);
            end
          end
          3'd4: begin
            if (r7_s) begin
              ill_s = 1'b1;
            end else begin
              tgt_s      = OP_HI;
              wr_en_s    = 1'b1;
              wr_data_s  = reg_rd_data - step_s;
              tgt_addr_s = reg_rd_data - step_s;
            end
          end
          3'd5: begin
            if (r7_s) begin
              ill_s = 1'b1;
            end else begin
              tgt_s      = PTR_HI;
              wr_en_s    = 1'b1;
              wr_data_s  = reg_rd_data - DATA_W'(2);
              tgt_addr_s = reg_rd_data - DATA_W'(2);
            end
          end
          default: begin
            tgt_s      = IDX_HI;
            tgt_addr_s = pc_r;
            pc_next_s  = pc2_s;
            base_s     = r7_s ? pc2_s : reg_rd_data;
          end
        endcase
      end
      IDX_HI: lo_s = IDX_LO;
      PTR_HI: lo_s = PTR_LO;
      IDX_LO: begin
        tgt_s      = (mode_r == 3'd7) ? PTR_HI : OP_HI;
        tgt_addr_s = base_r + word_s;
      end
      PTR_LO: begin
        tgt_s      = OP_HI;
        tgt_addr_s = word_s;
      end
      default: lo_s = OP_LO;
    endcase
  end

  // Fetch sequencer: each byte is a request cycle (phase 0) then a capture cycle (phase 1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      phase_r       <= 1'b0;
      mode_r        <= 3'd0;
      rsel_r        <= 3'd0;
      byte_r        <= 1'b0;
      pc_r          <= '0;
      base_r        <= '0;
      cur_addr_r    <= '0;
      hi_r          <= 8'h00;
      mem_rd_en_r   <= 1'b0;
      mem_addr_r    <= '0;
      out_operand_r <= '0;
      out_ea_r      <= '0;
      out_is_mem_r  <= 1'b0;
      out_pc_r      <= '0;
      err_r         <= 1'b0;
    end else if (flush) begin
      state_r     <= IDLE;
      phase_r     <= 1'b0;
      mem_rd_en_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mode_r  <= in_mode;
            rsel_r  <= in_reg;
            byte_r  <= in_byte;
            pc_r    <= in_pc;
            state_r <= CALC;
          end
        end
        CALC: begin
          base_r        <= base_s;
          out_pc_r      <= ill_s ? '0 : pc_next_s;
          out_is_mem_r  <= !ill_s && (mode_r != 3'd0);
          out_ea_r      <= '0;
          out_operand_r <= '0;
          if ((mode_r == 3'd0) && !ill_s) begin
            out_operand_r <= byte_r ? {8'h00, reg_rd_data[7:0]} : reg_rd_data;
          end
        end
        IDX_HI, PTR_HI, OP_HI: begin
          if (!phase_r) begin
            mem_rd_en_r <= 1'b0;
            phase_r     <= 1'b1;
          end else if ((state_r == OP_HI) && byte_r) begin
            out_operand_r <= {8'h00, mem_rd_data};
            state_r       <= DONE;
            phase_r       <= 1'b0;
          end else begin
            hi_r        <= mem_rd_data;
            state_r     <= lo_s;
            phase_r     <= 1'b0;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= cur_addr_r + ADDR_W'(1);
          end
        end
        IDX_LO, PTR_LO, OP_LO: begin
          if (!phase_r) begin
            mem_rd_en_r <= 1'b0;
            phase_r     <= 1'b1;
          end else if (state_r == OP_LO) begin
            out_operand_r <= word_s;
            state_r       <= DONE;
            phase_r       <= 1'b0;
          end else begin
            phase_r <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
            err_r   <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (launch_s) begin
        phase_r <= 1'b0;
        if (tgt_s == OP_HI) begin
          out_ea_r <= tgt_addr_s;
        end
        if ((tgt_s == DONE) || trap_s) begin
          state_r     <= DONE;
          mem_rd_en_r <= 1'b0;
          err_r       <= trap_s;
        end else begin
          state_r     <= tgt_s;
          mem_rd_en_r <= 1'b1;
          mem_addr_r  <= tgt_addr_s;
          cur_addr_r  <= tgt_addr_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// Scoreboard bench for pdp11_operand_fetch: regfile and byte memory models, hand-derived expectations.
module tb_pdp11_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_byte;
  logic [2:0]  in_mode, in_reg, reg_rd_addr, reg_wr_addr;
  logic [15:0] in_pc, reg_rd_data, reg_wr_data, mem_addr, out_operand, out_ea, out_pc;
  logic        reg_wr_en, mem_rd_en, out_valid, out_ready, out_is_mem, odd_addr_err;
  logic [7:0]  mem_rd_data;

  logic [15:0] regs [0:7];
  logic [7:0]  mem  [0:65535];
  logic        ld_en;
  logic [2:0]  ld_idx;
  logic [15:0] ld_val;

  typedef struct {
    logic [15:0] op, ea, pc;
    logic        is_mem, err;
    int          lat, nrd;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pdp11_operand_fetch dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_reg(in_reg),
    .in_byte(in_byte), .in_pc(in_pc),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_operand(out_operand),
    .out_ea(out_ea), .out_is_mem(out_is_mem), .out_pc(out_pc), .odd_addr_err(odd_addr_err)
  );

  assign reg_rd_data = regs[reg_rd_addr];

  // Sync byte memory and register file models
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (reg_wr_en) regs[reg_wr_addr] <= reg_wr_data;
    if (ld_en) regs[ld_idx] <= ld_val;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [2:0] r, input logic b,
                        input logic [15:0] pc, input logic [15:0] op, input logic [15:0] ea,
                        input logic [15:0] opc, input logic is_mem, input logic err,
                        input int nrd, input int hold);
    exp_t e, ex;
    int   cnt, rd;
    logic got;
    e.op = op; e.ea = ea; e.pc = opc; e.is_mem = is_mem; e.err = err;
    e.nrd = nrd; e.lat = 2 + 2 * nrd;
    sb.push_back(e);
    @(negedge clk);
    check_val({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_mode = m; in_reg = r; in_byte = b; in_pc = pc;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0; rd = 0; got = 1'b0;
    while (cnt < 40 && !got) begin
      @(negedge clk);
      cnt++;
      if (mem_rd_en) rd++;
      if (out_valid) got = 1'b1;
    end
    ex = sb.pop_front();
    check_val({tag, ".valid"}, {31'd0, got}, 32'd1);
    check_val({tag, ".latency"}, cnt, ex.lat);
    check_val({tag, ".reads"}, rd, ex.nrd);
    check_val({tag, ".operand"}, {16'd0, out_operand}, {16'd0, ex.op});
    check_val({tag, ".ea"}, {16'd0, out_ea}, {16'd0, ex.ea});
    check_val({tag, ".pc"}, {16'd0, out_pc}, {16'd0, ex.pc});
    check_val({tag, ".is_mem"}, {31'd0, out_is_mem}, {31'd0, ex.is_mem});
    check_val({tag, ".odd_err"}, {31'd0, odd_addr_err}, {31'd0, ex.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check_val({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check_val({tag, ".hold_operand"}, {16'd0, out_operand}, {16'd0, ex.op});
      check_val({tag, ".hold_ea"}, {16'd0, out_ea}, {16'd0, ex.ea});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int cnt, evt;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'hAB; mem[16'h0101] = 8'hCD; mem[16'h00FF] = 8'h5A;
    mem[16'h01FE] = 8'h77;
    mem[16'h0200] = 8'h00; mem[16'h0201] = 8'h10;
    mem[16'h0212] = 8'h11; mem[16'h0213] = 8'h22;
    mem[16'h0500] = 8'h00; mem[16'h0501] = 8'h04;
    mem[16'h0304] = 8'h04; mem[16'h0305] = 8'h00;
    mem[16'h0400] = 8'hBE; mem[16'h0401] = 8'hEF;
    mem[16'h0600] = 8'h12; mem[16'h0601] = 8'h34;
    mem[16'h0700] = 8'h01; mem[16'h0701] = 8'h00;
    mem[16'hFFFE] = 8'h9A; mem[16'hFFFF] = 8'hBC;
    mem_rd_data = 8'h00;
    ld_en = 1'b0; ld_idx = 3'd0; ld_val = 16'h0000;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 3'd0; in_reg = 3'd0;
    in_byte = 1'b0; in_pc = 16'h0000; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_reg(i[2:0], 16'h0000);
    @(negedge clk);
    check_val("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst.mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_val("rst.reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check_val("rst.operand", {16'd0, out_operand}, 32'd0);
    check_val("rst.odd_err", {31'd0, odd_addr_err}, 32'd0);
    reset_n = 1'b1;

    set_reg(3'd3, 16'h1234);
    set_reg(3'd2, 16'h0100);
    run_op("m0w",  3'd0, 3'd3, 1'b0, 16'h1000, 16'h1234, 16'h0000, 16'h1000, 1'b0, 1'b0, 0, 0);
    run_op("m0b",  3'd0, 3'd3, 1'b1, 16'h1000, 16'h0034, 16'h0000, 16'h1000, 1'b0, 1'b0, 0, 0);
    run_op("m2w",  3'd2, 3'd2, 1'b0, 16'h1000, 16'hABCD, 16'h0100, 16'h1000, 1'b1, 1'b0, 2, 0);
    check_val("m2w.r2", {16'd0, regs[2]}, 32'h0102);
    set_reg(3'd2, 16'h0100);
    run_op("m4b",  3'd4, 3'd2, 1'b1, 16'h1000, 16'h005A, 16'h00FF, 16'h1000, 1'b1, 1'b0, 1, 0);
    check_val("m4b.r2", {16'd0, regs[2]}, 32'h00FF);
    set_reg(3'd6, 16'h0200);
    run_op("m4b6", 3'd4, 3'd6, 1'b1, 16'h1000, 16'h0077, 16'h01FE, 16'h1000, 1'b1, 1'b0, 1, 0);
    check_val("m4b6.r6", {16'd0, regs[6]}, 32'h01FE);
    run_op("m6pc", 3'd6, 3'd7, 1'b0, 16'h0200, 16'h1122, 16'h0212, 16'h0202, 1'b1, 1'b0, 4, 0);
    set_reg(3'd1, 16'h0300);
    run_op("m7",   3'd7, 3'd1, 1'b0, 16'h0500, 16'hBEEF, 16'h0400, 16'h0502, 1'b1, 1'b0, 6, 0);
    run_op("imm",  3'd2, 3'd7, 1'b0, 16'h0600, 16'h1234, 16'h0600, 16'h0602, 1'b1, 1'b0, 2, 5);
    run_op("abs",  3'd3, 3'd7, 1'b0, 16'h0700, 16'hABCD, 16'h0100, 16'h0702, 1'b1, 1'b0, 4, 0);
    set_reg(3'd4, 16'h0700);
    run_op("m3",   3'd3, 3'd4, 1'b0, 16'h1000, 16'hABCD, 16'h0100, 16'h1000, 1'b1, 1'b0, 4, 0);
    check_val("m3.r4", {16'd0, regs[4]}, 32'h0702);
    set_reg(3'd5, 16'h0702);
    run_op("m5",   3'd5, 3'd5, 1'b0, 16'h1000, 16'hABCD, 16'h0100, 16'h1000, 1'b1, 1'b0, 4, 0);
    check_val("m5.r5", {16'd0, regs[5]}, 32'h0700);
    set_reg(3'd0, 16'h0100);
    run_op("m1b",  3'd1, 3'd0, 1'b1, 16'h1000, 16'h00AB, 16'h0100, 16'h1000, 1'b1, 1'b0, 1, 0);
    run_op("ill0", 3'd0, 3'd7, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("ill4", 3'd4, 3'd7, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
    set_reg(3'd0, 16'h0000);
    run_op("wrap", 3'd4, 3'd0, 1'b0, 16'h1000, 16'h9ABC, 16'hFFFE, 16'h1000, 1'b1, 1'b0, 2, 0);
    check_val("wrap.r0", {16'd0, regs[0]}, 32'hFFFE);
    set_reg(3'd0, 16'h00FF);
`ifdef OPFETCH_ODD_ADDR_TRAP_EN
    run_op("odd",  3'd1, 3'd0, 1'b0, 16'h1000, 16'h0000, 16'h00FF, 16'h1000, 1'b1, 1'b1, 0, 0);
`else
    run_op("odd",  3'd1, 3'd0, 1'b0, 16'h1000, 16'h5AAB, 16'h00FF, 16'h1000, 1'b1, 1'b0, 2, 0);
`endif

    // Flush during the first pointer-byte request of a mode-7 fetch
    @(negedge clk);
    in_valid = 1'b1; in_mode = 3'd7; in_reg = 3'd1; in_byte = 1'b0; in_pc = 16'h0500;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check_val("flush.ptr_req", {31'd0, mem_rd_en}, 32'd1);
    check_val("flush.ptr_addr", {16'd0, mem_addr}, 32'h0304);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    evt = 0;
    for (cnt = 0; cnt < 20; cnt++) begin
      @(negedge clk);
      if (mem_rd_en || reg_wr_en || out_valid) evt++;
    end
    check_val("flush.quiet", evt, 0);
    check_val("flush.in_ready", {31'd0, in_ready}, 32'd1);
    check_val("flush.r1", {16'd0, regs[1]}, 32'h0300);
    run_op("post", 3'd0, 3'd3, 1'b0, 16'h1000, 16'h1234, 16'h0000, 16'h1000, 1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
